prog_rom_arbiter: RTL and testbench

PROG_ROM_ARBITER -- requirements
Module: prog_rom_arbiter

---
 rtl/prog_rom_arbiter.sv | 128 ++++++++++++
 tb/tb_prog_rom_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_rom_arbiter.sv
// rtl/prog_rom_arbiter.sv - program ROM arbiter for CPU fetch and debug readback, 2-cycle pipeline
// Optional debug port and starvation guard enabled by defining PROG_ROM_DBG_PORT_EN.
module prog_rom_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_fetch_req,
  input  logic [10:0] cpu_pc,
  output logic        cpu_gnt,
  output logic [13:0] cpu_instr,
  output logic        cpu_instr_valid,
  input  logic        dbg_req,
  input  logic [10:0] dbg_addr,
  output logic        dbg_ack,
  output logic [13:0] dbg_data,
  output logic [10:0] rom_addr,
  input  logic [13:0] rom_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2
  } grant_t;

  grant_t      grant;
  grant_t      s1_tag;
  logic [10:0] grant_addr;

`ifdef PROG_ROM_DBG_PORT_EN
  logic [1:0] starv_cnt;
  logic       dbg_inflight;
  logic       dbg_eligible;

  assign dbg_eligible = dbg_req && !dbg_inflight;

  // CPU wins unless it is idle or has already starved debug for three grants.
  always_comb begin
    grant      = IDLE;
    grant_addr = rom_addr;
    if (!rst_n) begin
      grant = IDLE;
    end else if (dbg_eligible && ((starv_cnt == 2'd3) || !cpu_fetch_req)) begin
      grant      = GNT_DBG;
      grant_addr = dbg_addr;
    end else if (cpu_fetch_req) begin
      grant      = GNT_CPU;
      grant_addr = cpu_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starv_cnt    <= 2'd0;
      dbg_inflight <= 1'b0;
    end else begin
      if ((grant == GNT_DBG) || !dbg_eligible) begin
        starv_cnt <= 2'd0;
      end else if (grant == GNT_CPU) begin
        starv_cnt <= starv_cnt + 2'd1;
      end
      // Cleared at the end of the ack cycle, so a new grant waits one more cycle.
      if (grant == GNT_DBG) begin
        dbg_inflight <= 1'b1;
      end else if (dbg_ack) begin
        dbg_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_ack  <= 1'b0;
      dbg_data <= 14'd0;
    end else begin
      dbg_ack <= (s1_tag == GNT_DBG);
      if (s1_tag == GNT_DBG) begin
        dbg_data <= rom_data;
      end
    end
  end
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_req, dbg_addr};

  always_comb begin
    grant      = (rst_n && cpu_fetch_req) ? GNT_CPU : IDLE;
    grant_addr = cpu_pc;
  end

  assign dbg_ack  = 1'b0;
  assign dbg_data = 14'd0;
`endif

  assign cpu_gnt = (grant == GNT_CPU);

  // Stage 1: address to the ROM plus the owner tag of that access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag   <= IDLE;
      rom_addr <= 11'd0;
    end else begin
      s1_tag <= grant;
      if (grant != IDLE) begin
        rom_addr <= grant_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_instr_valid <= 1'b0;
      cpu_instr       <= 14'd0;
    end else begin
      cpu_instr_valid <= (s1_tag == GNT_CPU);
      if (s1_tag == GNT_CPU) begin
        cpu_instr <= rom_data;
      end
    end
  end

  assign busy = (s1_tag != IDLE) || cpu_instr_valid || dbg_ack;

  a_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    !(cpu_instr_valid && dbg_ack));

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// tb/tb_prog_rom_arbiter.sv - randomized self-checking bench for prog_rom_arbiter
module tb_prog_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_fetch_req = 1'b0;
  logic [10:0] cpu_pc = 11'd0;
  logic        cpu_gnt;
  logic [13:0] cpu_instr;
  logic        cpu_instr_valid;
  logic        dbg_req = 1'b0;
  logic [10:0] dbg_addr = 11'd0;
  logic        dbg_ack;
  logic [13:0] dbg_data;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic        busy;

  logic [13:0] rom [0:2047];

  prog_rom_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_fetch_req  (cpu_fetch_req),
    .cpu_pc         (cpu_pc),
    .cpu_gnt        (cpu_gnt),
    .cpu_instr      (cpu_instr),
    .cpu_instr_valid(cpu_instr_valid),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_ack        (dbg_ack),
    .dbg_data       (dbg_data),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  typedef struct {
    bit          is_dbg;
    logic [10:0] addr;
    int          due;
  } acc_t;

  acc_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_starv = 0;
  logic [13:0] m_cpu_instr = 14'd0;
  logic [13:0] m_dbg_data = 14'd0;
  logic [10:0] m_rom_addr = 11'd0;
  int          n_cpu_obs = 0;
  int          n_ack_obs = 0;
  bit          dbg_built;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_cpu_instr", 32'(cpu_instr), 32'd0);
    check("rst_cpu_valid", 32'(cpu_instr_valid), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_dbg_data", 32'(dbg_data), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  // One clock cycle: check pipeline outputs against the model, drive inputs, check the grant.
  task automatic step(input logic f, input logic [10:0] pc, input logic dr, input logic [10:0] da);
    logic exp_cv, exp_ack, exp_busy, dbg_out, dbg_elig, g_cpu, g_dbg;
    acc_t e;
    @(posedge clk);
    cyc++;
    #1;
    exp_cv = 1'b0;
    exp_ack = 1'b0;
    exp_busy = 1'b0;
    dbg_out = 1'b0;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        exp_busy = 1'b1;
        if (q[i].is_dbg) begin
          exp_ack = 1'b1;
          m_dbg_data = rom[q[i].addr];
        end else begin
          exp_cv = 1'b1;
          m_cpu_instr = rom[q[i].addr];
        end
      end
      if (q[i].due == cyc + 1) exp_busy = 1'b1;
      if (q[i].is_dbg) dbg_out = 1'b1;
    end
    check("cpu_instr_valid", 32'(cpu_instr_valid), 32'(exp_cv));
    check("dbg_ack", 32'(dbg_ack), 32'(exp_ack));
    check("busy", 32'(busy), 32'(exp_busy));
    check("cpu_instr", 32'(cpu_instr), 32'(m_cpu_instr));
    check("dbg_data", 32'(dbg_data), 32'(m_dbg_data));
    check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    if (dbg_ack) n_ack_obs++;
    while (q.size() > 0 && q[0].due <= cyc) q.delete(0);

    cpu_fetch_req = f;
    cpu_pc = pc;
    dbg_req = dr;
    dbg_addr = da;
    #1;
    dbg_elig = dbg_built && dr && !dbg_out;
    g_dbg = dbg_elig && ((m_starv == 3) || !f);
    g_cpu = f && !g_dbg;
    check("cpu_gnt", 32'(cpu_gnt), 32'(g_cpu));
    if (cpu_gnt) n_cpu_obs++;
    if (g_cpu || g_dbg) begin
      e.is_dbg = g_dbg;
      e.addr = g_dbg ? da : pc;
      e.due = cyc + 2;
      q.push_back(e);
      m_rom_addr = e.addr;
    end
    if (g_dbg || !dbg_elig) m_starv = 0;
    else if (g_cpu) m_starv++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 11'd0, 1'b0, 11'd0);
  endtask

  // Reset asserted mid-cycle while accesses are in flight; they must vanish.
  task automatic do_reset_mid();
    #1;
    rst_n = 1'b0;
    cpu_fetch_req = 1'b1;
    dbg_req = 1'b1;
    #1;
    check_reset_outputs();
    q.delete();
    m_cpu_instr = 14'd0;
    m_dbg_data = 14'd0;
    m_rom_addr = 11'd0;
    m_starv = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check("rst_hold_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_hold_busy", 32'(busy), 32'd0);
    end
    cpu_fetch_req = 1'b0;
    dbg_req = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef PROG_ROM_DBG_PORT_EN
    dbg_built = 1'b1;
`else
    dbg_built = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) rom[i] = 14'($urandom);
    rom[11'h000] = 14'h300F;
    rom[11'h001] = 14'h00A4;
    rom[11'h002] = 14'h01A5;
    rom[11'h003] = 14'h0103;
    rom[11'h004] = 14'h3001;
    rom[11'h015] = 14'h301E;
    rom[11'h01F] = 14'h0008;

    #1;
    rst_n = 1'b0;
    cpu_fetch_req = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    cpu_fetch_req = 1'b0;
    rst_n = 1'b1;

    step(1'b1, 11'h000, 1'b0, 11'd0);
    idle(2);
    check("single_fetch_word", 32'(cpu_instr), 32'h300F);

    for (int i = 1; i <= 4; i++) step(1'b1, 11'(i), 1'b0, 11'd0);
    idle(2);
    check("burst_last_word", 32'(cpu_instr), 32'h3001);

    step(1'b0, 11'd0, 1'b1, 11'h015);
    step(1'b0, 11'd0, 1'b1, 11'h015);
    step(1'b0, 11'd0, 1'b0, 11'd0);
    check("dbg_read_word", 32'(dbg_data), dbg_built ? 32'h301E : 32'h0);
    check("dbg_cpu_unchanged", 32'(cpu_instr), 32'h3001);
    idle(2);

    n_cpu_obs = 0;
    n_ack_obs = 0;
    for (int i = 0; i < 18; i++) step(1'b1, 11'($urandom), 1'b1, 11'($urandom));
    idle(3);
    check("contend_cpu_grants", 32'(n_cpu_obs), dbg_built ? 32'd15 : 32'd18);
    check("contend_dbg_acks", 32'(n_ack_obs), dbg_built ? 32'd3 : 32'd0);

    step(1'b0, 11'd0, 1'b1, 11'h015);
    step(1'b1, 11'h005, 1'b0, 11'd0);
    step(1'b0, 11'd0, 1'b0, 11'd0);
    do_reset_mid();
    step(1'b1, 11'h01F, 1'b0, 11'd0);
    idle(2);
    check("post_reset_fetch", 32'(cpu_instr), 32'h0008);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 11'($urandom), 1'($urandom_range(0, 1)), 11'($urandom));
      if (i == 300) do_reset_mid();
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
